// File: rtl/rr_pkg.sv
// rtl/rr_pkg.sv - shared types and helpers for the weighted round-robin arbiter
package rr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // A zero weight still earns one beat per tenure.
  function automatic logic [31:0] weff(input logic [31:0] w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

  // Pointer advance with explicit wrap at n, so non-power-of-two n never
  // produces an index >= n.
  function automatic logic [31:0] next_ptr(input logic [31:0] idx, input logic [31:0] n);
    return (idx == n - 32'd1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - first set request at or above ptr, wrapping at N
module rr_priority_pick
  import rr_pkg::*;
#(
  parameter  int N = 8,
  localparam int M = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [M-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [M-1:0] idx,
  output logic         found
);

  localparam logic [M:0] NV = N;

  logic [2*N-1:0] dbl_req;
  logic [N-1:0]   rot;
  logic [N-1:0]   iso;
  logic [M-1:0]   rel;
  logic [M:0]     sum;

  // Rotate so ptr lands at bit 0, keep the lowest set bit, rotate back.
  assign dbl_req = {req, req};
  assign rot     = N'(dbl_req >> ptr);
  assign iso     = rot & (~rot + N'(1));
  assign onehot  = N'(({iso, iso} << ptr) >> N);
  assign found   = |req;

  // Encode the ptr-relative position of the isolated bit.
  always_comb begin
    rel = '0;
    for (int i = 0; i < N; i++) begin
      if (iso[i]) rel = M'(i);
    end
  end

  assign sum = {1'b0, rel} + {1'b0, ptr};
  assign idx = (sum >= NV) ? M'(sum - NV) : M'(sum);

endmodule

// File: rtl/weighted_rr_arbiter.sv
// rtl/weighted_rr_arbiter.sv - weighted round-robin arbiter with credit-based grant tenure
module weighted_rr_arbiter
  import rr_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int WW = 4,
  localparam int M  = $clog2(N)
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_en,
  input  logic [N-1:0]    i_req,
  input  logic [N*WW-1:0] i_weight,
  output logic [N-1:0]    o_gnt,
  output logic [M-1:0]    o_gnt_id,
  output logic            o_busy,
  output logic            o_last
);

  state_t        state, state_n;
  logic [M-1:0]  ptr, ptr_n;
  logic [M-1:0]  h, h_n;
  logic [WW-1:0] cnt, cnt_n;
  logic [WW-1:0] lim_h, lim_n;
  logic [M-1:0]  pick_ptr, pick_idx;
  logic [N-1:0]  pick_oh, gnt_n;
  logic          pick_found, last_n;

  // While holding, the only pick that matters is the one taken on release,
  // which searches from just past the holder.
  assign pick_ptr = (state == GRANT) ? M'(next_ptr(32'(h), N)) : ptr;
  assign lim_h    = WW'(weff(32'(i_weight[h*WW +: WW])) - 32'd1);

  rr_priority_pick #(.N(N)) u_pick (
    .req    (i_req),
    .ptr    (pick_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  // Next-state: grant from idle, count beats, release and hand over without a bubble.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    h_n     = h;
    gnt_n   = o_gnt;
    if (!i_en) begin
      state_n = IDLE;
      cnt_n   = '0;
      h_n     = '0;
      gnt_n   = '0;
    end else if (state == IDLE) begin
      if (pick_found) begin
        state_n = GRANT;
        h_n     = pick_idx;
        cnt_n   = '0;
        gnt_n   = pick_oh;
      end
    end else if (!i_req[h] || (cnt >= lim_h)) begin
      ptr_n = pick_ptr;
      cnt_n = '0;
      if (pick_found) begin
        h_n   = pick_idx;
        gnt_n = pick_oh;
      end else begin
        state_n = IDLE;
        h_n     = '0;
        gnt_n   = '0;
      end
    end else begin
      cnt_n = cnt + WW'(1);
    end
    lim_n  = WW'(weff(32'(i_weight[h_n*WW +: WW])) - 32'd1);
    last_n = (state_n == GRANT) && (cnt_n == lim_n);
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      h      <= '0;
      o_gnt  <= '0;
      o_last <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      cnt    <= cnt_n;
      h      <= h_n;
      o_gnt  <= gnt_n;
      o_last <= last_n;
    end
  end

  assign o_gnt_id = h;
  assign o_busy   = (state == GRANT);

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// tb/tb_weighted_rr_arbiter.sv - scoreboard bench for weighted_rr_arbiter at N=8 and N=5
module tb_weighted_rr_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [7:0]  req;
  logic [31:0] weight;

  logic [7:0] gnt8;
  logic [2:0] id8;
  logic       busy8, last8;
  logic [4:0] gnt5;
  logic [2:0] id5;
  logic       busy5, last5;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       busy;
    logic       last;
    logic [2:0] ptr;
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];

  int nn[2] = '{8, 5};
  int m_busy[2];
  int m_h[2];
  int m_used[2];
  int m_ptr[2];

  always #5 clk = ~clk;

  weighted_rr_arbiter #(.N(8), .WW(4)) u8 (
    .i_clk    (clk),
    .i_rstn   (rstn),
    .i_en     (en),
    .i_req    (req),
    .i_weight (weight),
    .o_gnt    (gnt8),
    .o_gnt_id (id8),
    .o_busy   (busy8),
    .o_last   (last8)
  );

  weighted_rr_arbiter #(.N(5), .WW(4)) u5 (
    .i_clk    (clk),
    .i_rstn   (rstn),
    .i_en     (en),
    .i_req    (req[4:0]),
    .i_weight (weight[19:0]),
    .o_gnt    (gnt5),
    .o_gnt_id (id5),
    .o_busy   (busy5),
    .o_last   (last5)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int wgt(int i);
    int w;
    w = int'(weight[i*4 +: 4]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int pickm(int k, int start);
    for (int i = 0; i < nn[k]; i++) begin
      int j;
      j = (start + i) % nn[k];
      if (req[j]) return j;
    end
    return -1;
  endfunction

  // Reference: one tenure = up to wgt(holder) granted beats, then search from holder+1.
  task automatic model_step(int k);
    int p;
    bit rel;
    if (!rstn) begin
      m_busy[k] = 0; m_h[k] = 0; m_used[k] = 0; m_ptr[k] = 0;
    end else if (!en) begin
      m_busy[k] = 0; m_used[k] = 0;
    end else if (m_busy[k] == 0) begin
      p = pickm(k, m_ptr[k]);
      if (p >= 0) begin
        m_busy[k] = 1; m_h[k] = p; m_used[k] = 0;
      end
    end else begin
      rel = 0;
      if (!req[m_h[k]]) rel = 1;
      else if (m_used[k] + 1 >= wgt(m_h[k])) rel = 1;
      else m_used[k]++;
      if (rel) begin
        m_ptr[k]  = (m_h[k] + 1) % nn[k];
        m_used[k] = 0;
        p = pickm(k, m_ptr[k]);
        if (p >= 0) m_h[k] = p;
        else m_busy[k] = 0;
      end
    end
  endtask

  function automatic exp_t model_out(int k);
    exp_t e;
    e.gnt  = (m_busy[k] != 0) ? 8'(1 << m_h[k]) : 8'h00;
    e.id   = (m_busy[k] != 0) ? 3'(m_h[k]) : 3'd0;
    e.busy = (m_busy[k] != 0);
    e.last = (m_busy[k] != 0) && (m_used[k] == wgt(m_h[k]) - 1);
    e.ptr  = 3'(m_ptr[k]);
    return e;
  endfunction

  task automatic tick();
    model_step(0);
    model_step(1);
    q8.push_back(model_out(0));
    q5.push_back(model_out(1));
    @(negedge clk);
  endtask

  // Monitor: pop one expectation per DUT after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk("n8.gnt",  32'(gnt8),     32'(e.gnt));
        chk("n8.id",   32'(id8),      32'(e.id));
        chk("n8.busy", 32'(busy8),    32'(e.busy));
        chk("n8.last", 32'(last8),    32'(e.last));
        chk("n8.ptr",  32'(u8.ptr),   32'(e.ptr));
      end
      if (q5.size() > 0) begin
        e = q5.pop_front();
        chk("n5.gnt",  32'(gnt5),     32'(e.gnt));
        chk("n5.id",   32'(id5),      32'(e.id));
        chk("n5.busy", 32'(busy5),    32'(e.busy));
        chk("n5.last", 32'(last5),    32'(e.last));
        chk("n5.ptr",  32'(u5.ptr),   32'(e.ptr));
      end
    end
  end

  initial begin
    rstn   = 1'b0;
    en     = 1'b0;
    req    = 8'h00;
    weight = 32'h11111111;
    @(negedge clk);
    tick();
    tick();

    rstn = 1'b1; en = 1'b1; req = 8'h04;
    repeat (4) tick();

    weight = 32'h87654321; req = 8'h03;
    repeat (10) tick();

    req = 8'h00; tick();
    req = 8'h28; repeat (3) tick();
    req = 8'h20; repeat (3) tick();

    weight = 32'h11111111; req = 8'h11;
    repeat (8) tick();

    weight = 32'h11111301; req = 8'h02;
    repeat (3) tick();
    en = 1'b0; repeat (2) tick();
    en = 1'b1; req = 8'h06; repeat (6) tick();

    weight = 32'h87654321; req = 8'hff;
    repeat (3) tick();
    #2 rstn = 1'b0;
    #1;
    chk("areset.gnt8",  32'(gnt8),  32'h0);
    chk("areset.busy8", 32'(busy8), 32'h0);
    chk("areset.last8", 32'(last8), 32'h0);
    chk("areset.id8",   32'(id8),   32'h0);
    chk("areset.gnt5",  32'(gnt5),  32'h0);
    chk("areset.busy5", 32'(busy5), 32'h0);
    tick();
    tick();
    rstn = 1'b1;
    repeat (5) tick();

    repeat (400) begin
      if ($urandom_range(0, 9) < 3) req = 8'($urandom);
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 29) == 0) weight = $urandom;
      tick();
    end

    @(negedge clk);
    @(negedge clk);
    chk("drain", 32'(q8.size() + q5.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/weighted_rr_arbiter.md
# weighted_rr_arbiter

Parametrised N-way weighted round-robin arbiter with grant hold and credit-based tenure, the successor to our free-running-pointer round-robin. Each granted requester keeps the grant for up to its programmed weight in consecutive beats, then the pointer advances past the winner. Handover between winners needs no idle cycle. The block sits in front of shared resources (bus ports, memory banks) where requesters need bursts.

## Interface
- N, 8: number of requesters, 2..32, not required to be a power of two.
- WW, 4: weight width in bits.
- M, localparam $clog2(N): index width.
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_en  in  1  arbitration enable.
- i_req  in  N  request vector; bit k is requester k.
- i_weight  in  N*WW  per-requester weight; slice [k*WW +: WW]; quasi-static.
- o_gnt  out  N  registered one-hot grant, or all zero.
- o_gnt_id  out  M  registered index of the holder; 0 when idle.
- o_busy  out  1  registered; high while any grant is held.
- o_last  out  1  registered; high on the holder's final credited beat.

## Operation
- State: FSM {IDLE, GRANT}, pointer ptr[M-1:0], beat counter cnt[WW-1:0], holder id.
- Effective weight: w_eff = (w==0) ? 1 : w. Range 1..2^WW-1.
- Pick function: the first set bit of i_req at or after index ptr, searching upward with wrap from N-1 to 0. The result is one-hot or none.
- IDLE: if i_en and |i_req, move to GRANT. Set holder = pick(ptr), cnt = 0, o_gnt = onehot(holder). Otherwise stay in IDLE with outputs at 0.
- GRANT: a beat is a cycle with o_gnt[h] & i_req[h]. On a beat, cnt increments.
- Release condition in GRANT, evaluated each cycle:
  - a beat occurs with cnt == w_eff-1 (credit exhausted), or
  - i_req[h] == 0 (holder withdrew; that cycle is not a beat).
- On release:
  - ptr <= (h==N-1) ? 0 : h+1, using explicit wrap, not modulo 2^M.
  - A new pick is taken from the current i_req with the new ptr.
  - If the pick is non-empty, grant it on the same edge with cnt = 0 (no bubble). Otherwise go to IDLE.
- Sole requester: after its credit runs out it re-wins immediately, starting a new tenure with cnt = 0.
- o_last: driven high for the cycle where cnt == w_eff-1 while in GRANT.
- i_en low: at the next edge o_gnt, o_busy and o_last clear and the FSM goes to IDLE. ptr is unchanged and cnt resets to 0.
- i_weight changes mid-tenure take effect immediately. If cnt >= the new w_eff-1, the current beat is the last.
- Non-power-of-two N: ptr never takes values >= N. Request bits >= N do not exist.

## Timing
- Reset, async assert: state IDLE, ptr=0, cnt=0, o_gnt=0, o_gnt_id=0, o_busy=0, o_last=0. Reset asserted mid-tenure drops the grant immediately.
- Latency from IDLE: a request sampled at edge t gives the grant visible after edge t. That is one cycle of latency.
- A holder with weight W requesting continuously gets exactly W consecutive granted cycles.
- Handover: holder A's last beat is at cycle c. The next winner B is granted at cycle c+1 with no gap.
- Holder withdrawal at cycle c: the grant moves or clears at c+1. That one cycle is wasted.

## Structure
- Package rr_pkg holds:
  - typedef state_t {IDLE, GRANT};
  - function weff(w), which maps 0 to 1;
  - function next_ptr(idx, n), which applies the wrap.
- Sub-module rr_priority_pick (combinational). Parameter N; inputs req[N] and ptr[M]; outputs onehot[N], idx[M], found. It uses rotate-right, isolate-lowest-set-bit, rotate-left over a 2N-wide concatenation, then reduces ptr-relative indices with the N wrap. It is instantiated once.
- Top level: FSM, ptr/cnt/holder registers, and output registers. Target size is 150-300 lines.

## Test plan
- Reset and single request: N=8, all weights 1, i_req=0x04 after reset. Expect o_gnt=0x04 and o_gnt_id=2 one cycle later, with o_last high every cycle while the request holds.
- Weighted burst: weights {1,2,3,...}, with req 0x03 held. Expect the grant sequence 0,1,1,0,1,1,... and no idle cycles between tenures.
- Withdrawal: holder 3 with weight 4 drops i_req after 2 beats. Expect the grant to move to the next requester above 3 on the following cycle, and ptr=4.
- Wrap with N=5: req=0b10001, all weights 1, ptr starting at 4. Expect grants 4,0,4,0. ptr must never reach 5..7.
- Weight 0 and enable: weight[1]=0 with req=0x02 gives one beat per tenure. Deasserting i_en mid-tenure clears o_gnt next cycle. Re-enabling resumes from the retained ptr.
- Async reset mid-tenure: assert i_rstn low between edges. All outputs must read 0 immediately, and after release arbitration restarts from ptr=0.
